// File: rtl/module_transmisor_hamming_if.sv
// Bus bundle for the Hamming serial transmitter: word input handshake,
// error-injection mask, and the serial line and status outputs.
interface module_transmisor_hamming_if;
    logic [3:0] datos_in;
    logic       valido_in;
    logic [7:0] mascara_error;
    logic       listo_out;
    logic       tx_serial;
    logic       ocupado;
    logic [7:0] palabra_tx;
    logic       trama_fin;

    modport master (
        output datos_in,
        output valido_in,
        output mascara_error,
        input  listo_out,
        input  tx_serial,
        input  ocupado,
        input  palabra_tx,
        input  trama_fin
    );

    modport slave (
        input  datos_in,
        input  valido_in,
        input  mascara_error,
        output listo_out,
        output tx_serial,
        output ocupado,
        output palabra_tx,
        output trama_fin
    );
endinterface

// File: rtl/module_transmisor_hamming.sv
// Encodes a nibble into an 8-bit SECDED Hamming codeword, applies an optional
// error mask and sends it as a UART-style frame (start 0, 8 bits LSB first, stop 1).
module module_transmisor_hamming #(
    parameter int CLKS_POR_BIT = 10
) (
    input logic                         clk,
    input logic                         rst,
    module_transmisor_hamming_if.slave  bus
);

    localparam int CW = (CLKS_POR_BIT > 2) ? $clog2(CLKS_POR_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_POR_BIT - 1);
    localparam logic [CW-1:0] CNT_UNO = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATOS = 2'd2,
        STOP  = 2'd3
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          tx_q, tx_d;
    logic          ocupado_q, ocupado_d;
    logic [7:0]    palabra_q, palabra_d;
    logic          fin_q, fin_d;

    logic          listo_s;
    logic          aceptar_s;
    logic          fin_bit_s;
    logic [2:0]    idx_sig_s;

    function automatic logic paridad4(input logic [3:0] v);
        return v[0] ^ v[1] ^ v[2] ^ v[3];
    endfunction

    // Bit map: [0]=p1 [1]=p2 [2]=d0 [3]=p4 [4]=d1 [5]=d2 [6]=d3 [7]=overall parity
    function automatic logic [7:0] hamming_codificar(input logic [3:0] d);
        logic [7:0] cw;
        cw[0] = paridad4({1'b0, d[3], d[1], d[0]});
        cw[1] = paridad4({1'b0, d[3], d[2], d[0]});
        cw[2] = d[0];
        cw[3] = paridad4({1'b0, d[3], d[2], d[1]});
        cw[4] = d[1];
        cw[5] = d[2];
        cw[6] = d[3];
        cw[7] = ^cw[6:0];
        return cw;
    endfunction

    assign listo_s   = (estado_q == IDLE) && !rst;
    assign aceptar_s = listo_s && bus.valido_in;
    assign fin_bit_s = (cnt_q == CNT_MAX);
    assign idx_sig_s = idx_q + 3'd1;

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        ocupado_d = ocupado_q;
        palabra_d = palabra_q;
        fin_d     = 1'b0;

        case (estado_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = 3'd0;
                if (aceptar_s) begin
                    estado_d  = START;
                    tx_d      = 1'b0;
                    ocupado_d = 1'b1;
                    palabra_d = hamming_codificar(bus.datos_in) ^ bus.mascara_error;
                end else begin
                    estado_d  = IDLE;
                    tx_d      = 1'b1;
                    ocupado_d = 1'b0;
                end
            end
            START: begin
                if (fin_bit_s) begin
                    estado_d = DATOS;
                    cnt_d    = '0;
                    idx_d    = 3'd0;
                    tx_d     = palabra_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_UNO;
                end
            end
            DATOS: begin
                if (fin_bit_s) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        estado_d = STOP;
                        tx_d     = 1'b1;
                    end else begin
                        idx_d = idx_sig_s;
                        tx_d  = palabra_q[idx_sig_s];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_UNO;
                end
            end
            STOP: begin
                if (fin_bit_s) begin
                    estado_d  = IDLE;
                    cnt_d     = '0;
                    ocupado_d = 1'b0;
                    fin_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_UNO;
                end
            end
            default: begin
                estado_d  = IDLE;
                cnt_d     = '0;
                idx_d     = 3'd0;
                tx_d      = 1'b1;
                ocupado_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            tx_q      <= 1'b1;
            ocupado_q <= 1'b0;
            palabra_q <= 8'h00;
            fin_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
            ocupado_q <= ocupado_d;
            palabra_q <= palabra_d;
            fin_q     <= fin_d;
        end
    end

    assign bus.listo_out  = listo_s;
    assign bus.tx_serial  = tx_q;
    assign bus.ocupado    = ocupado_q;
    assign bus.palabra_tx = palabra_q;
    assign bus.trama_fin  = fin_q;

endmodule

// File: doc/module_transmisor_hamming.md
MODULE_TRANSMISOR_HAMMING -- requirements
Module: module_transmisor_hamming

Interface
REQ-001 Parameter: CLKS_POR_BIT, default 10, clock cycles per serial bit; the block SHALL support any value >= 2.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 datos_in  input  4  data nibble to encode, d3..d0.
REQ-005 valido_in  input  1  datos_in and mascara_error are valid this cycle.
REQ-006 mascara_error  input  8  error-injection mask, XORed onto the codeword; 0 means no error.
REQ-007 listo_out  output  1  block can accept a word this cycle.
REQ-008 tx_serial  output  1  serial line, registered; idle high.
REQ-009 ocupado  output  1  frame in progress, registered.
REQ-010 palabra_tx  output  8  last transmitted codeword after injection, registered, for display/LEDs.
REQ-011 trama_fin  output  1  one-cycle pulse when a frame's stop bit completes.

Function
REQ-012 The codeword bit map SHALL be: [0]=p1=d0^d1^d3, [1]=p2=d0^d2^d3, [2]=d0, [3]=p4=d1^d2^d3, [4]=d1, [5]=d2, [6]=d3, [7]=pg=XOR of bits [6:0].
REQ-013 The transmitted word SHALL be codeword XOR mascara_error, with both captured at acceptance.
REQ-014 Acceptance SHALL occur on a rising edge where valido_in=1 and listo_out=1; the block SHALL ignore inputs at all other times.
REQ-015 listo_out SHALL be 1 only in state IDLE with rst=0; it SHALL be combinational from state.
REQ-016 The FSM SHALL have four states: IDLE -> START on acceptance; START -> DATOS after CLKS_POR_BIT cycles; DATOS -> STOP after 8 bits; STOP -> IDLE after CLKS_POR_BIT cycles.
REQ-017 Frame format SHALL be: start bit 0, then 8 data bits LSB first (bit 0 first), then stop bit 1.
REQ-018 Each bit SHALL be held on tx_serial for exactly CLKS_POR_BIT cycles, counted by a cycle counter that wraps 0..CLKS_POR_BIT-1.
REQ-019 A 3-bit index SHALL select the data bit; it SHALL advance on each counter wrap in DATOS.
REQ-020 Latency: tx_serial SHALL go 0 in the first cycle after the acceptance edge.
REQ-021 A frame SHALL last 10*CLKS_POR_BIT cycles.
REQ-022 palabra_tx SHALL update at the acceptance edge and hold until the next acceptance.
REQ-023 ocupado SHALL be 1 from the cycle after acceptance through the last STOP cycle, else 0.
REQ-024 trama_fin SHALL pulse high for 1 cycle, in the first IDLE cycle after STOP.
REQ-025 IDLE SHALL last at least 1 cycle between frames; with valido_in held high, back-to-back frames SHALL be separated by exactly 1 idle-high cycle.
REQ-026 A valido_in asserted during a frame SHALL NOT be queued; it SHALL be dropped unless still asserted in IDLE.
REQ-027 In IDLE, tx_serial SHALL be 1.

Reset
REQ-028 While rst=1, at each edge: state=IDLE, counters=0, tx_serial=1, ocupado=0, palabra_tx=8'h00, trama_fin=0; listo_out SHALL be 0 while rst is high.
REQ-029 Reset asserted mid-frame SHALL abort the frame: tx_serial=1 from the next cycle, and no trama_fin is produced.
REQ-030 listo_out SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-031 datos_in=4'hB, mask 0, CLKS_POR_BIT=10 -> palabra_tx=8'h55; line shows 0, then 1,0,1,0,1,0,1,0, then 1, each 10 cycles; trama_fin pulses 100 cycles after acceptance.
REQ-032 datos_in=4'h0 -> 8'h00; datos_in=4'hF -> 8'hFF; decode of both by the team's SECDED receiver yields no_error.
REQ-033 datos_in=4'hB, mascara_error=8'h04 -> palabra_tx=8'h51; receiver reports a single error at bit 2 and corrects it to 4'hB; mask 8'h05 -> receiver flags a double error.
REQ-034 valido_in held high for 3 frames -> exactly 1 idle-high cycle between stop and start; no word lost or duplicated; valido_in pulsed mid-frame -> ignored.
REQ-035 rst pulsed during DATOS bit 4 -> tx_serial=1 the next cycle, ocupado=0, no trama_fin, listo_out=1 after release; next frame is correct.
